xcom_tx_arb: RTL
================

Name: xcom_tx_arb

Overview:
- Round-robin arbiter that shares one xcom serial TX link among NREQ independent requesters (command sources, status reporters, sync generators).
- Accepts one packet (8-bit header + 32-bit data) from the winning requester and holds it in a register.
- Presents the packet to the link with a valid/ready handshake, waits for the serial transfer to complete, then enforces a programmable inter-packet gap before arbitrating again.
- Sits between the requesters and the xcom link transmitter, in the x_clk_i domain.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- GAP_W, 4, width of the inter-packet gap configuration.

Ports:
- x_clk_i  in  1  link clock.
- x_rst_i  in  1  asynchronous active-high reset.
- gap_cfg_i  in  GAP_W  idle cycles inserted after each packet completes.
- pri_en_i  in  1  when 1, requester 0 has strict priority over round-robin.
- req_vld_i  in  NREQ  per-requester packet valid.
- req_rdy_o  out  NREQ  per-requester accept, at most one bit high.
- req_header_i  in  NREQ*8  headers; requester k uses bits [8k+7:8k].
- req_data_i  in  NREQ*32  data; requester k uses bits [32k+31:32k].
- tx_vld_o  out  1  packet valid to the link.
- tx_rdy_i  in  1  link idle/ready.
- tx_header_o  out  8  header to the link.
- tx_data_o  out  32  data to the link.
- grant_o  out  NREQ  one-hot owner of the current packet; 0 when idle.
- busy_o  out  1  high whenever the FSM is not in ST_IDLE.

Behaviour:
- Reset values:
  - FSM in ST_IDLE.
  - tx_vld_o = 0, tx_header_o = 0, tx_data_o = 0, grant_o = 0, busy_o = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 wins first.
  - Gap counter = 0.
- Winner selection (combinational, used only in ST_IDLE):
  - If pri_en_i = 1 and req_vld_i[0] = 1, winner = 0.
  - Otherwise, winner = first k with req_vld_i[k] = 1, searching last+1, last+2, … with modulo-NREQ wrap.
- req_rdy_o:
  - req_rdy_o[winner] = 1 only in ST_IDLE while any req_vld_i bit is set; all other bits are 0.
  - req_rdy_o may depend combinationally on req_vld_i.
  - Requesters must not make req_vld_i depend on req_rdy_o.
- ST_IDLE:
  - If any request is valid: on that edge, capture the winner's header/data into tx_header_o/tx_data_o, set tx_vld_o = 1, set grant_o = onehot(winner), set last = winner, go to ST_SEND.
  - Latency: request accepted at edge T; tx_vld_o is high from T+1.
- ST_SEND:
  - Hold tx_vld_o, header and data stable.
  - When tx_vld_o & tx_rdy_i are both high on an edge: clear tx_vld_o, clear seen_busy, go to ST_WAIT.
  - tx_rdy_i may already be high on entry; acceptance can then occur on the first ST_SEND edge.
- ST_WAIT:
  - Set seen_busy when tx_rdy_i = 0.
  - When seen_busy = 1 and tx_rdy_i = 1: load gap counter with gap_cfg_i, clear grant_o, go to ST_GAP.
  - A tx_rdy_i that never drops keeps the FSM in ST_WAIT indefinitely; there is no timeout.
- ST_GAP:
  - If counter = 0, go to ST_IDLE; otherwise decrement.
  - Result: exactly gap_cfg_i + 1 cycles in ST_GAP.
  - gap_cfg_i is sampled only on entry to ST_GAP; changes mid-gap have no effect.
- tx_header_o/tx_data_o keep their last value after the packet and change only on the next acceptance.
- Withdrawal/switching: a requester dropping req_vld_i while not granted loses nothing. Requests arriving while busy wait for ST_IDLE.
- pri_en_i toggling mid-packet only affects the next arbitration.
- Reset asserted mid-packet: all state and outputs return to reset values immediately (asynchronously), including tx_vld_o = 0. The in-flight packet is dropped and the pointer returns to NREQ-1.
- Throughput ceiling: one packet per (link packet time + gap_cfg_i + 3) cycles.

Test Plan:
- Single request: req_vld_i = 4'b0100, header 8'h60, data 32'hDEADBEEF.
  - req_rdy_o[2] high for one cycle; tx_vld_o rises the next cycle with header 8'h60, data 32'hDEADBEEF; grant_o = 4'b0100.
- All four valid continuously after reset, pri_en_i = 0, gap_cfg_i = 0.
  - Grants go 0,1,2,3,0 in order.
  - Each tx_vld_o pulse ends on its link handshake; no second tx_vld_o before tx_rdy_i falls and rises again.
- Fairness: after requester 2 is served, requesters 1 and 3 are valid.
  - Requester 3 is granted before 1.
- Priority: pri_en_i = 1 with requesters 0 and 2 continuously valid.
  - Requester 0 wins every arbitration; requester 2 is never granted.
  - Clearing pri_en_i: requester 2 is granted next.
- Gap: gap_cfg_i = 3; link model drops tx_rdy_i for 20 cycles after acceptance.
  - busy_o stays high exactly 4 cycles after tx_rdy_i returns high; the next req_rdy_o appears on the 5th cycle.
  - Changing gap_cfg_i to 0 mid-gap does not shorten the gap.
- Reset mid-operation: assert x_rst_i while in ST_SEND with tx_vld_o = 1.
  - tx_vld_o, grant_o and busy_o go low without waiting for a clock edge.
  - After release, with all requests valid, requester 0 is granted first.

Source files
------------

// File: rtl/xcom_tx_arb_if.sv
// Requester and link-side signals of the xcom TX arbiter.
// The arbiter uses the master view: it accepts requests and drives the link.
// The slave view belongs to the requesters and the link transmitter.
interface xcom_tx_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_vld_i;
  logic [NREQ-1:0]    req_rdy_o;
  logic [NREQ*8-1:0]  req_header_i;
  logic [NREQ*32-1:0] req_data_i;
  logic               tx_vld_o;
  logic               tx_rdy_i;
  logic [7:0]         tx_header_o;
  logic [31:0]        tx_data_o;
  logic [NREQ-1:0]    grant_o;
  logic               busy_o;

  modport master (
    input  req_vld_i, req_header_i, req_data_i, tx_rdy_i,
    output req_rdy_o, tx_vld_o, tx_header_o, tx_data_o, grant_o, busy_o
  );

  modport slave (
    output req_vld_i, req_header_i, req_data_i, tx_rdy_i,
    input  req_rdy_o, tx_vld_o, tx_header_o, tx_data_o, grant_o, busy_o
  );
endinterface

// File: rtl/xcom_tx_arb.sv
// Round-robin arbiter sharing one xcom serial TX link among NREQ requesters.
// One packet (8-bit header + 32-bit data) is latched from the winner, offered
// to the link, the serial transfer is awaited (tx_rdy_i low then high again),
// and a programmable idle gap is inserted before the next arbitration.
module xcom_tx_arb #(
  parameter int NREQ  = 4,
  parameter int GAP_W = 4
) (
  input  logic             x_clk_i,
  input  logic             x_rst_i,
  input  logic [GAP_W-1:0] gap_cfg_i,
  input  logic             pri_en_i,
  xcom_tx_arb_if.master    bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [GAP_W-1:0] gap_cnt;
  logic             seen_busy;
  logic             tx_vld_r;
  logic [7:0]       tx_header_r;
  logic [31:0]      tx_data_r;
  logic [NREQ-1:0]  grant_r;
  logic             busy_r;

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;
  logic [NREQ-1:0]  req_rdy;

  // Winner search: requester 0 under strict priority, else first valid after last.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    if (pri_en_i && bus.req_vld_i[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int s = 1; s <= NREQ; s++) begin
        cand = int'(last) + s;
        if (cand >= NREQ) cand = cand - NREQ;
        cand_idx = IDX_W'(cand);
        if (!win_vld && bus.req_vld_i[cand_idx]) begin
          win_vld = 1'b1;
          win_idx = cand_idx;
        end
      end
    end
  end

  // Accept strobe to the winner, only offered while the arbiter is idle.
  always_comb begin
    req_rdy = '0;
    if ((state == ST_IDLE) && win_vld) req_rdy[win_idx] = 1'b1;
  end

  // Packet FSM: capture, offer to link, await transfer, then idle gap.
  always_ff @(posedge x_clk_i or posedge x_rst_i) begin
    if (x_rst_i) begin
      state       <= ST_IDLE;
      last        <= IDX_W'(NREQ - 1);
      gap_cnt     <= '0;
      seen_busy   <= 1'b0;
      tx_vld_r    <= 1'b0;
      tx_header_r <= '0;
      tx_data_r   <= '0;
      grant_r     <= '0;
      busy_r      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (win_vld) begin
            tx_header_r <= bus.req_header_i[{win_idx, 3'b000} +: 8];
            tx_data_r   <= bus.req_data_i[{win_idx, 5'b00000} +: 32];
            tx_vld_r    <= 1'b1;
            grant_r     <= NREQ'(1) << win_idx;
            last        <= win_idx;
            busy_r      <= 1'b1;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_vld_r && bus.tx_rdy_i) begin
            tx_vld_r  <= 1'b0;
            seen_busy <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The link signals completion by dropping ready and raising it again.
          if (!bus.tx_rdy_i) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            gap_cnt <= gap_cfg_i;
            grant_r <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_rdy_o   = req_rdy;
  assign bus.tx_vld_o    = tx_vld_r;
  assign bus.tx_header_o = tx_header_r;
  assign bus.tx_data_o   = tx_data_r;
  assign bus.grant_o     = grant_r;
  assign bus.busy_o      = busy_r;

endmodule
